// File: rtl/ymat_entry_fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ymat_entry_fetch_pkg -- shared constants, FSM encoding and helpers. Rev 1.0
//------------------------------------------------------------------------------
package ymat_entry_fetch_pkg;

  localparam int MAT_DIM     = 64;
  localparam int LINE_W      = 256;
  localparam int LANES       = 16;
  localparam int SRAM_ADDR_W = 8;
  localparam int COORD_W     = 11;
  localparam int CNT_W       = 16;
  localparam int DIM_W       = $clog2(MAT_DIM);
  localparam int IDX_W       = 2 * DIM_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } fetch_state_e;

  function automatic logic coord_in_range(input logic [COORD_W-1:0] row,
                                          input logic [COORD_W-1:0] col);
    return (row < COORD_W'(MAT_DIM)) && (col < COORD_W'(MAT_DIM));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ymat_entry_fetch_lane_sel.sv
`default_nettype none
//------------------------------------------------------------------------------
// ymat_lane_sel -- combinational line-to-entry lane multiplexer. Rev 1.0
//------------------------------------------------------------------------------
module ymat_lane_sel
  import ymat_entry_fetch_pkg::*;
#(
  parameter int ENTRY_W = 16,
  parameter int SEL_W   = $clog2(LINE_W / ENTRY_W)
) (
  input  logic [LINE_W-1:0]  i_line,
  input  logic [SEL_W-1:0]   i_lane,
  output logic [ENTRY_W-1:0] o_entry
);

  localparam int LANE_CNT = LINE_W / ENTRY_W;

  always_comb begin
    o_entry = '0;
    for (int k = 0; k < LANE_CNT; k++) begin
      if (i_lane == SEL_W'(k)) begin
        o_entry = i_line[k*ENTRY_W +: ENTRY_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ymat_entry_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// ymat_entry_fetch -- change record to Y-matrix entry fetch with one-line hit
// buffer, single record in flight. Rev 1.0
//------------------------------------------------------------------------------
module ymat_entry_fetch
  import ymat_entry_fetch_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int ENTRY_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_chg_valid,
  output logic                   o_chg_ready,
  input  logic [COORD_W-1:0]     i_chg_row,
  input  logic [COORD_W-1:0]     i_chg_col,
  input  logic                   i_inval,
  output logic                   o_sram_re,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  input  logic [LINE_W-1:0]      i_sram_rdata,
  output logic                   o_ent_valid,
  input  logic                   i_ent_ready,
  output logic [COORD_W-1:0]     o_ent_row,
  output logic [COORD_W-1:0]     o_ent_col,
  output logic [ENTRY_W-1:0]     o_ent_data,
  output logic                   o_ent_err,
  output logic [CNT_W-1:0]       o_hit_cnt,
  output logic [CNT_W-1:0]       o_miss_cnt
);

  localparam int LANE_SEL_W = $clog2(LINE_W / ENTRY_W);
  // READ already spends one latency cycle, so WAIT covers the remaining ones
  // and CAPTURE lands exactly on the cycle the line is valid.
  localparam int WAIT_CYC   = READ_LAT - 1;

  fetch_state_e r_state;
  fetch_state_e w_next;

  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [LANE_SEL_W-1:0]  r_lane;
  logic [1:0]             r_wait_cnt;
  logic                   r_buf_valid;
  logic [SRAM_ADDR_W-1:0] r_buf_addr;
  logic [LINE_W-1:0]      r_buf_line;
  logic [COORD_W-1:0]     r_ent_row;
  logic [COORD_W-1:0]     r_ent_col;
  logic [ENTRY_W-1:0]     r_ent_data;
  logic                   r_ent_err;
  logic [CNT_W-1:0]       r_hit_cnt;
  logic [CNT_W-1:0]       r_miss_cnt;

  logic [IDX_W-1:0]       w_index;
  logic [SRAM_ADDR_W-1:0] w_line;
  logic [LANE_SEL_W-1:0]  w_lane;
  logic                   w_in_range;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_wait_done;
  logic [ENTRY_W-1:0]     w_buf_entry;
  logic [ENTRY_W-1:0]     w_sram_entry;

  assign w_index     = {i_chg_row[DIM_W-1:0], i_chg_col[DIM_W-1:0]};
  assign w_line      = SRAM_ADDR_W'(w_index >> LANE_SEL_W);
  assign w_lane      = w_index[LANE_SEL_W-1:0];
  assign w_in_range  = coord_in_range(i_chg_row, i_chg_col);
  // A line being invalidated this cycle is already stale, so it cannot hit.
  assign w_hit       = w_in_range && r_buf_valid && !i_inval && (r_buf_addr == w_line);
  assign w_accept    = i_chg_valid && o_chg_ready;
  assign w_wait_done = (r_wait_cnt == 2'(WAIT_CYC - 1));

  ymat_lane_sel #(.ENTRY_W(ENTRY_W)) u_buf_sel (
    .i_line  (r_buf_line),
    .i_lane  (w_lane),
    .o_entry (w_buf_entry)
  );

  ymat_lane_sel #(.ENTRY_W(ENTRY_W)) u_sram_sel (
    .i_line  (i_sram_rdata),
    .i_lane  (r_lane),
    .o_entry (w_sram_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (!w_in_range || w_hit) ? ST_OUT : ST_READ;
        end
      end
      ST_READ:    w_next = (WAIT_CYC == 0) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    w_next = w_wait_done ? ST_CAPTURE : ST_WAIT;
      ST_CAPTURE: w_next = ST_OUT;
      ST_OUT:     w_next = i_ent_ready ? ST_IDLE : ST_OUT;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_chg_ready = 1'b0;
    o_sram_re   = 1'b0;
    o_ent_valid = 1'b0;
    if (!rst) begin
      o_chg_ready = (r_state == ST_IDLE);
      o_sram_re   = (r_state == ST_READ);
      o_ent_valid = (r_state == ST_OUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr <= '0;
      r_lane      <= '0;
      r_wait_cnt  <= '0;
      r_ent_row   <= '0;
      r_ent_col   <= '0;
      r_ent_data  <= '0;
      r_ent_err   <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
      if (w_accept) begin
        r_ent_row <= i_chg_row;
        r_ent_col <= i_chg_col;
        if (!w_in_range) begin
          r_ent_err  <= 1'b1;
          r_ent_data <= '0;
        end else if (w_hit) begin
          r_ent_err  <= 1'b0;
          r_ent_data <= w_buf_entry;
          r_hit_cnt  <= sat_inc(r_hit_cnt);
        end else begin
          r_ent_err   <= 1'b0;
          r_sram_addr <= w_line;
          r_lane      <= w_lane;
          r_miss_cnt  <= sat_inc(r_miss_cnt);
        end
      end
      if (r_state == ST_CAPTURE) begin
        r_ent_data <= w_sram_entry;
      end
    end
  end

  // Capture takes priority over a coincident invalidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_line  <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_sram_addr;
      r_buf_line  <= i_sram_rdata;
    end else if (i_inval) begin
      r_buf_valid <= 1'b0;
    end
  end

  assign o_sram_addr = r_sram_addr;
  assign o_ent_row   = r_ent_row;
  assign o_ent_col   = r_ent_col;
  assign o_ent_data  = r_ent_data;
  assign o_ent_err   = r_ent_err;
  assign o_hit_cnt   = r_hit_cnt;
  assign o_miss_cnt  = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ymat_entry_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ymat_entry_fetch -- directed bench for READ_LAT=1 and READ_LAT=3. Rev 1.0
//------------------------------------------------------------------------------
module tb_ymat_entry_fetch;

  localparam logic [255:0] JUNK = {16{16'hDEAD}};

  logic         clk = 1'b0;
  logic         rst;
  logic         valid1, valid3;
  logic [10:0]  row, col;
  logic         inval, ent_ready;

  logic         ready1, re1, ev1, err1;
  logic [7:0]   addr1;
  logic [255:0] rdata1;
  logic [10:0]  erow1, ecol1;
  logic [15:0]  data1, hit1, miss1;

  logic         ready3, re3, ev3, err3;
  logic [7:0]   addr3;
  logic [255:0] rdata3;
  logic [10:0]  erow3, ecol3;
  logic [15:0]  data3, hit3, miss3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ymat_entry_fetch #(.READ_LAT(1), .ENTRY_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .i_chg_valid(valid1), .o_chg_ready(ready1),
    .i_chg_row(row), .i_chg_col(col), .i_inval(inval),
    .o_sram_re(re1), .o_sram_addr(addr1), .i_sram_rdata(rdata1),
    .o_ent_valid(ev1), .i_ent_ready(ent_ready), .o_ent_row(erow1), .o_ent_col(ecol1),
    .o_ent_data(data1), .o_ent_err(err1), .o_hit_cnt(hit1), .o_miss_cnt(miss1)
  );

  ymat_entry_fetch #(.READ_LAT(3), .ENTRY_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .i_chg_valid(valid3), .o_chg_ready(ready3),
    .i_chg_row(row), .i_chg_col(col), .i_inval(inval),
    .o_sram_re(re3), .o_sram_addr(addr3), .i_sram_rdata(rdata3),
    .o_ent_valid(ev3), .i_ent_ready(ent_ready), .o_ent_row(erow3), .o_ent_col(ecol3),
    .o_ent_data(data3), .o_ent_err(err3), .o_hit_cnt(hit3), .o_miss_cnt(miss3)
  );

  // SRAM model: lane k of line a holds {a, k, ~k}; junk outside the valid cycle.
  function automatic logic [255:0] line_of(input logic [7:0] a);
    logic [255:0] l;
    for (int k = 0; k < 16; k++) begin
      l[16*k +: 16] = {a, 4'(k), ~4'(k)};
    end
    return l;
  endfunction

  logic [2:0] rp1, rp3;
  logic [7:0] ap1 [3];
  logic [7:0] ap3 [3];

  always @(posedge clk) begin
    rp1    <= {rp1[1:0], re1};
    rp3    <= {rp3[1:0], re3};
    ap1[0] <= addr1;  ap1[1] <= ap1[0];  ap1[2] <= ap1[1];
    ap3[0] <= addr3;  ap3[1] <= ap3[0];  ap3[2] <= ap3[1];
  end

  assign rdata1 = (rp1[0] === 1'b1) ? line_of(ap1[0]) : JUNK;
  assign rdata3 = (rp3[2] === 1'b1) ? line_of(ap3[2]) : JUNK;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid1 = 1'b0; valid3 = 1'b0; row = '0; col = '0;
    inval = 1'b0; ent_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_chg_ready", {31'd0, ready1}, 0);
    chk("rst_outputs", {re1, ev1, err1, addr1, data1}, 0);
    chk("rst_coords_cnt", {erow1, ecol1, hit1[4:0], miss1[4:0]}, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {30'd0, ready1, ready3}, 32'd3);

    // Miss (2,5): line 08, lane 5.
    row = 11'd2; col = 11'd5; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    chk("miss_re_t1", {re1, addr1}, {1'b1, 8'h08});
    chk("miss_busy", {31'd0, ready1}, 0);
    tick();
    chk("miss_t2_quiet", {re1, ev1}, 0);
    tick();
    chk("miss_ev_t3", {ev1, err1}, 2'b10);
    chk("miss_data", data1, 16'h085A);
    chk("miss_coords", {erow1, ecol1}, {11'd2, 11'd5});
    chk("miss_cnts", {hit1, miss1}, {16'd0, 16'd1});
    tick();
    chk("miss_back_idle", {ready1, ev1}, 2'b10);

    // Hit (2,9): buffered line 08, lane 9.
    col = 11'd9; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    chk("hit_ev_t1", {ev1, re1, err1}, 3'b100);
    chk("hit_data", data1, 16'h0896);
    chk("hit_cnts", {hit1, miss1}, {16'd1, 16'd1});
    tick();

    // Out of range (70,3).
    row = 11'd70; col = 11'd3; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    chk("err_ev_t1", {ev1, err1, re1}, 3'b110);
    chk("err_data", {erow1, data1}, {11'd70, 16'h0000});
    chk("err_cnts", {hit1, miss1}, {16'd1, 16'd1});
    tick();

    // Backpressure on a hit (2,12): outputs stable, no new accept.
    ent_ready = 1'b0;
    row = 11'd2; col = 11'd12; valid1 = 1'b1;
    tick();
    row = 11'd3; col = 11'd0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {ev1, ready1, err1, erow1, ecol1, data1},
          {1'b1, 1'b0, 1'b0, 11'd2, 11'd12, 16'h08C3});
      tick();
    end
    valid1 = 1'b0;
    ent_ready = 1'b1;
    tick();
    chk("stall_release", {ev1, ready1}, 2'b01);
    chk("stall_cnts", {hit1, miss1}, {16'd2, 16'd1});

    // Invalidate, then (2,6) must miss on line 08.
    inval = 1'b1;
    tick(); inval = 1'b0;
    row = 11'd2; col = 11'd6; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    chk("inval_re", {re1, ev1, addr1}, {1'b1, 1'b0, 8'h08});
    tick(); tick();
    chk("inval_data", {ev1, data1}, {1'b1, 16'h0869});
    chk("inval_cnts", {hit1, miss1}, {16'd2, 16'd2});
    tick();

    // READ_LAT=3: (63,63) -> line FF, lane 15.
    row = 11'd63; col = 11'd63; valid3 = 1'b1;
    tick(); valid3 = 1'b0;
    chk("lat3_re", {re3, addr3}, {1'b1, 8'hFF});
    tick(); tick(); tick();
    chk("lat3_t4_quiet", {re3, ev3}, 0);
    tick();
    chk("lat3_ev_t5", {ev3, err3, data3}, {1'b1, 1'b0, 16'hFFF0});
    chk("lat3_cnts", {hit3, miss3}, {16'd0, 16'd1});
    tick();

    // Reset while waiting on a (5,5) read; the late line must be ignored.
    row = 11'd5; col = 11'd5; valid3 = 1'b1;
    tick(); valid3 = 1'b0;
    chk("abort_re", {re3, addr3}, {1'b1, 8'h14});
    tick();
    rst = 1'b1;
    tick();
    chk("abort_in_rst", {ready3, ev3}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_ev", {ev3, ready3, data3}, {1'b0, 1'b1, 16'h0000});
    end
    chk("abort_cnts", {hit3, miss3}, 0);

    // Buffer was dropped by reset, so (2,5) misses again.
    row = 11'd2; col = 11'd5; valid3 = 1'b1;
    tick(); valid3 = 1'b0;
    chk("post_rst_miss", {re3, addr3}, {1'b1, 8'h08});
    tick(); tick(); tick(); tick();
    chk("post_rst_data", {ev3, data3, miss3}, {1'b1, 16'h085A, 16'd1});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
